// File: rtl/rle_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rle_arbiter_if
// Brief    : Requester, encoder and status signals of the two-input RLE arbiter
// Revision : 1.0 - initial release
// ============================================================================
interface rle_arbiter_if;
    logic       rts0;
    logic       rts1;
    logic       den0;
    logic       den1;
    logic [7:0] din0;
    logic [7:0] din1;
    logic       cts0;
    logic       cts1;
    logic       enc_rts;
    logic       enc_den;
    logic [7:0] enc_din;
    logic       enc_cts;
    logic [1:0] grant;
    logic [1:0] state;
    logic [7:0] nbytes;

    modport master (
        output rts0, rts1, den0, den1, din0, din1, enc_cts,
        input  cts0, cts1, enc_rts, enc_den, enc_din, grant, state, nbytes
    );

    modport slave (
        input  rts0, rts1, den0, den1, din0, din1, enc_cts,
        output cts0, cts1, enc_rts, enc_den, enc_din, grant, state, nbytes
    );
endinterface
`default_nettype wire

// File: rtl/rle_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rle_arbiter
// Brief    : Round-robin arbiter sharing one runlength encoder between two
//            byte requesters. Optional macro RLE_ARB_QUANTUM_EN caps a grant
//            at QUANTUM bytes.
// Revision : 1.0 - initial release
// ============================================================================
module rle_arbiter #(
    parameter logic [7:0]  QUANTUM    = 8'd255,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  wire logic    clk,
    input  wire logic    rst,
    rle_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FLUSH = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [15:0] c_GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t      r_state;
    state_t      w_next_state;
    logic        r_last;        // last-served requester, doubles as current owner
    logic [1:0]  r_den_q;
    logic        r_enc_den;
    logic [7:0]  r_enc_din;
    logic [7:0]  r_nbytes;
    logic [15:0] r_gap_cnt;

    logic        w_owned;
    logic [1:0]  w_grant;
    logic        w_cts0;
    logic        w_cts1;
    logic [1:0]  w_edge;
    logic        w_accept;
    logic        w_owner_rts;
    logic [7:0]  w_owner_din;
    logic        w_pick;
    logic        w_quantum_hit;

    assign w_owned  = (r_state == ST_GRANT) || (r_state == ST_FLUSH);
    assign w_grant  = w_owned ? (r_last ? 2'b10 : 2'b01) : 2'b00;
    assign w_cts0   = w_grant[0] & bus.enc_cts & (r_state == ST_GRANT);
    assign w_cts1   = w_grant[1] & bus.enc_cts & (r_state == ST_GRANT);
    assign w_edge   = {bus.den1 & ~r_den_q[1], bus.den0 & ~r_den_q[0]};
    assign w_accept = |(w_edge & {w_cts1, w_cts0});

    assign w_owner_rts = r_last ? bus.rts1 : bus.rts0;
    assign w_owner_din = r_last ? bus.din1 : bus.din0;

    // On a tie the requester that was not served last wins.
    assign w_pick = (bus.rts0 && bus.rts1) ? ~r_last : bus.rts1;

`ifdef RLE_ARB_QUANTUM_EN
    assign w_quantum_hit = w_accept && (r_nbytes == QUANTUM - 8'd1);
`else
    logic w_unused_quantum;
    assign w_unused_quantum = ^QUANTUM;
    assign w_quantum_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.rts0 || bus.rts1) begin
                    w_next_state = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (!w_owner_rts || w_quantum_hit) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!bus.enc_cts) begin
                    w_next_state = ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last    <= 1'b1;
            r_den_q   <= 2'b00;
            r_enc_den <= 1'b0;
            r_enc_din <= 8'h00;
            r_nbytes  <= 8'h00;
            r_gap_cnt <= 16'd0;
        end else begin
            r_den_q   <= {bus.den1, bus.den0};
            r_enc_den <= w_accept;
            if (w_accept) begin
                r_enc_din <= w_owner_din;
                r_nbytes  <= r_nbytes + 8'd1;
            end else if ((r_state == ST_GAP) && (w_next_state == ST_IDLE)) begin
                r_nbytes <= 8'h00;
            end
            if ((r_state == ST_IDLE) && (w_next_state == ST_GRANT)) begin
                r_last <= w_pick;
            end
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 16'd1 : 16'd0;
        end
    end

    assign bus.cts0    = w_cts0;
    assign bus.cts1    = w_cts1;
    assign bus.enc_rts = (r_state == ST_GRANT);
    assign bus.enc_den = r_enc_den;
    assign bus.enc_din = r_enc_din;
    assign bus.grant   = w_grant;
    assign bus.state   = r_state;
    assign bus.nbytes  = r_nbytes;

endmodule
`default_nettype wire

// File: tb/tb_rle_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rle_arbiter
// Brief    : Directed self-checking bench for rle_arbiter (RLE_ARB_QUANTUM_EN aware)
// Revision : 1.0 - initial release
// ============================================================================
module tb_rle_arbiter;

    localparam int c_GAP = 2;

    logic clk = 1'b0;
    logic rst;

    rle_arbiter_if bus();

    rle_arbiter #(
        .QUANTUM    (8'd255),
        .GAP_CYCLES (c_GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int         n_pass  = 0;
    int         n_total = 0;
    logic [7:0] pulse_q[$];
    int         frame_q[$];
    logic [1:0] prev_state;
    int         flush_age = 0;
    bit         cts_hold  = 1'b0;

    // Record every encoder strobe and the byte count at each GRANT->FLUSH.
    always @(negedge clk) begin
        if (bus.enc_den === 1'b1) pulse_q.push_back(bus.enc_din);
        if (bus.state === 2'd2 && prev_state === 2'd1) frame_q.push_back(int'(bus.nbytes));
        prev_state = bus.state;
    end

    // Encoder model: ready except briefly after a flush begins, or when held off.
    initial begin
        bus.enc_cts = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bus.state === 2'd2) flush_age++;
            else flush_age = 0;
            bus.enc_cts = !(flush_age >= 2) && !cts_hold;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [1:0] s, input string what);
        int n = 0;
        while (bus.state !== s && n < 40) begin
            tick();
            n++;
        end
        n_total++;
        if (bus.state === s) n_pass++;
        else $display("FAIL %s: state=%0d required %0d", what, bus.state, s);
    endtask

    task automatic send_byte(input int k, input logic [7:0] b);
        int n = 0;
        while (((k == 0) ? bus.cts0 : bus.cts1) !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            n_total++;
            $display("FAIL cts%0d_wait: cts=0 required 1", k);
        end
        if (k == 0) begin bus.din0 = b; bus.den0 = 1'b1; end
        else        begin bus.din1 = b; bus.den1 = 1'b1; end
        tick();
        bus.den0 = 1'b0;
        bus.den1 = 1'b0;
        tick();
    endtask

    task automatic end_frame(input int k, input bit reraise);
        int n = 0;
        if (k == 0) bus.rts0 = 1'b0;
        else        bus.rts1 = 1'b0;
        wait_state(2'd2, "enter_flush");
        n_total++;
        if (bus.enc_rts === 1'b0) n_pass++;
        else $display("FAIL flush_enc_rts: enc_rts=%b required 0", bus.enc_rts);
        wait_state(2'd3, "enter_gap");
        if (reraise) begin
            if (k == 0) bus.rts0 = 1'b1;
            else        bus.rts1 = 1'b1;
        end
        while (bus.state === 2'd3 && n < 10) begin
            n++;
            tick();
        end
        n_total++;
        if (n == c_GAP) n_pass++;
        else $display("FAIL gap_len: cycles=%0d required %0d", n, c_GAP);
        n_total++;
        if (bus.state === 2'd0 && bus.nbytes === 8'd0 && bus.grant === 2'b00) n_pass++;
        else $display("FAIL after_gap: state=%0d nbytes=%0d grant=%b required 0/0/00",
                      bus.state, bus.nbytes, bus.grant);
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        bus.rts0 = 1'b0; bus.rts1 = 1'b0;
        bus.den0 = 1'b0; bus.den1 = 1'b0;
        bus.din0 = 8'h00; bus.din1 = 8'h00;
        cts_hold = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        pulse_q.delete();
        frame_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.rts0 = 1'b0; bus.rts1 = 1'b0;
        bus.den0 = 1'b0; bus.den1 = 1'b0;
        bus.din0 = 8'h00; bus.din1 = 8'h00;
        repeat (3) tick();
        n_total++;
        if (bus.state === 2'd0) n_pass++;
        else $display("FAIL reset_state: state=%0d required 0", bus.state);
        n_total++;
        if (bus.grant === 2'b00) n_pass++;
        else $display("FAIL reset_grant: grant=%b required 00", bus.grant);
        n_total++;
        if (bus.nbytes === 8'd0) n_pass++;
        else $display("FAIL reset_nbytes: nbytes=%0d required 0", bus.nbytes);
        n_total++;
        if ({bus.enc_rts, bus.enc_den, bus.enc_din, bus.cts0, bus.cts1} === 12'h000) n_pass++;
        else $display("FAIL reset_outputs: rts/den/din/cts=%b%b%h%b%b required all 0",
                      bus.enc_rts, bus.enc_den, bus.enc_din, bus.cts0, bus.cts1);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic [31:0] got;
        reset_dut();
        bus.rts0 = 1'b1;
        tick();
        n_total++;
        if (bus.state === 2'd1 && bus.grant === 2'b01 && bus.enc_rts === 1'b1) n_pass++;
        else $display("FAIL single_grant: state=%0d grant=%b enc_rts=%b required 1/01/1",
                      bus.state, bus.grant, bus.enc_rts);
        send_byte(0, 8'hAD);
        send_byte(0, 8'h5E);
        send_byte(0, 8'h5E);
        send_byte(0, 8'h1B);
        end_frame(0, 1'b0);
        got = (pulse_q.size() == 4) ? {pulse_q[0], pulse_q[1], pulse_q[2], pulse_q[3]} : 32'h0;
        n_total++;
        if (pulse_q.size() == 4 && got === 32'hAD5E5E1B) n_pass++;
        else $display("FAIL single_bytes: n=%0d bytes=%h required 4 / AD5E5E1B", pulse_q.size(), got);
        n_total++;
        if (frame_q.size() == 1 && frame_q[0] == 4) n_pass++;
        else $display("FAIL single_nbytes: frames=%0d first=%0d required 1 / 4",
                      frame_q.size(), (frame_q.size() > 0) ? frame_q[0] : -1);
    endtask

    task automatic test_tie();
        logic [1:0]  exp_g[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [7:0]  byt[4]   = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic [31:0] got;
        reset_dut();
        bus.rts0 = 1'b1;
        bus.rts1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_total++;
            if (bus.grant === exp_g[i]) n_pass++;
            else $display("FAIL tie_grant%0d: grant=%b required %b", i, bus.grant, exp_g[i]);
            send_byte(i % 2, byt[i]);
            if (i == 0) begin
                n_total++;
                if (bus.cts1 === 1'b0) n_pass++;
                else $display("FAIL tie_cts1: cts1=%b required 0", bus.cts1);
            end
            end_frame(i % 2, i < 2);
        end
        got = (pulse_q.size() == 4) ? {pulse_q[0], pulse_q[1], pulse_q[2], pulse_q[3]} : 32'h0;
        n_total++;
        if (got === 32'h11223344) n_pass++;
        else $display("FAIL tie_order: bytes=%h required 11223344", got);
    endtask

    task automatic test_intruder();
        reset_dut();
        bus.rts0 = 1'b1;
        tick();
        send_byte(0, 8'h01);
        for (int i = 0; i < 3; i++) begin
            bus.din1 = 8'hC6;
            bus.den1 = 1'b1;
            tick();
            bus.den1 = 1'b0;
            tick();
        end
        n_total++;
        if (pulse_q.size() == 1 && bus.nbytes === 8'd1) n_pass++;
        else $display("FAIL intruder: pulses=%0d nbytes=%0d required 1/1", pulse_q.size(), bus.nbytes);
        cts_hold = 1'b1;
        tick();
        n_total++;
        if (bus.cts0 === 1'b0) n_pass++;
        else $display("FAIL hold_cts0: cts0=%b required 0", bus.cts0);
        bus.din0 = 8'h99;
        bus.den0 = 1'b1;
        tick();
        bus.den0 = 1'b0;
        tick();
        n_total++;
        if (pulse_q.size() == 1 && bus.nbytes === 8'd1) n_pass++;
        else $display("FAIL hold_drop: pulses=%0d nbytes=%0d required 1/1", pulse_q.size(), bus.nbytes);
        cts_hold = 1'b0;
        tick();
        send_byte(0, 8'h02);
        n_total++;
        if (bus.nbytes === 8'd2 && pulse_q.size() == 2 && pulse_q[1] === 8'h02) n_pass++;
        else $display("FAIL resume: nbytes=%0d pulses=%0d required 2/2", bus.nbytes, pulse_q.size());
        end_frame(0, 1'b0);
    endtask

    task automatic test_long_run();
        int bad = 0;
        reset_dut();
        bus.rts0 = 1'b1;
        tick();
        for (int i = 0; i < 258; i++) send_byte(0, 8'h77);
        end_frame(0, 1'b0);
        foreach (pulse_q[i]) if (pulse_q[i] !== 8'h77) bad++;
        n_total++;
        if (pulse_q.size() == 258 && bad == 0) n_pass++;
        else $display("FAIL long_pulses: n=%0d bad=%0d required 258/0", pulse_q.size(), bad);
`ifdef RLE_ARB_QUANTUM_EN
        n_total++;
        if (frame_q.size() == 2 && frame_q[0] == 255 && frame_q[1] == 3) n_pass++;
        else $display("FAIL long_frames: frames=%0d first=%0d required 2 frames 255,3",
                      frame_q.size(), (frame_q.size() > 0) ? frame_q[0] : -1);
`else
        n_total++;
        if (frame_q.size() == 1 && frame_q[0] == 2) n_pass++;
        else $display("FAIL long_frames: frames=%0d first=%0d required 1 frame, nbytes 2",
                      frame_q.size(), (frame_q.size() > 0) ? frame_q[0] : -1);
`endif
    endtask

    task automatic test_abort();
        reset_dut();
        bus.rts0 = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) send_byte(0, 8'(i + 1));
        bus.din0 = 8'h55;
        bus.den0 = 1'b1;
        rst      = 1'b1;
        tick();
        n_total++;
        if (bus.enc_rts === 1'b0 && bus.grant === 2'b00 && bus.nbytes === 8'd0) n_pass++;
        else $display("FAIL abort_out: enc_rts=%b grant=%b nbytes=%0d required 0/00/0",
                      bus.enc_rts, bus.grant, bus.nbytes);
        n_total++;
        if (bus.enc_den === 1'b0 && bus.cts0 === 1'b0 && bus.cts1 === 1'b0) n_pass++;
        else $display("FAIL abort_strobe: enc_den=%b cts0=%b cts1=%b required 0/0/0",
                      bus.enc_den, bus.cts0, bus.cts1);
        rst      = 1'b0;
        bus.den0 = 1'b0;
        bus.rts0 = 1'b0;
        tick();
        tick();
        n_total++;
        if (pulse_q.size() == 10) n_pass++;
        else $display("FAIL abort_stray: pulses=%0d required 10", pulse_q.size());
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_intruder();
        test_long_run();
        test_abort();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rle_arbiter.md
RLE_ARBITER -- requirements
Module: rle_arbiter

Interface
REQ-001 Parameter QUANTUM, default 8'd255: maximum bytes forwarded per grant when RLE_ARB_QUANTUM_EN is defined.
REQ-002 Parameter GAP_CYCLES, default 2: idle cycles between the end of one frame and the next grant.
REQ-003 Port clk  input  1  the single clock; all logic on posedge clk.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Ports rts0, rts1  input  1  requester k asks to send a frame; held high for the whole frame.
REQ-006 Ports den0, den1  input  1  requester k data strobe; a byte is offered on a sampled 0->1 edge.
REQ-007 Ports din0, din1  input  8  requester k data byte, valid while den_k is high.
REQ-008 Ports cts0, cts1  output  1  requester k may strobe the next byte.
REQ-009 Port enc_rts  output  1  frame request to the shared runlength encoder.
REQ-010 Port enc_den  output  1  one-cycle data strobe to the encoder.
REQ-011 Port enc_din  output  8  byte to the encoder.
REQ-012 Port enc_cts  input  1  encoder ready for a byte; low when the frame is flushed.
REQ-013 Port grant  output  2  one-hot owner of the encoder; 2'b00 when none.
REQ-014 Port state  output  2  FSM state: IDLE=0, GRANT=1, FLUSH=2, GAP=3.
REQ-015 Port nbytes  output  8  bytes forwarded in the current grant; wraps 255->0.

Function
REQ-016 IDLE: if exactly one rts_k is high, SHALL grant it; if both, grant the requester not served last (round robin); next state GRANT.
REQ-017 GRANT: enc_rts SHALL be 1; cts_k = grant[k] & enc_cts & (state==GRANT), combinational; cts of the ungranted requester SHALL be 0.
REQ-018 den_k SHALL be registered once; an edge is prev=0, cur=1 on the granted requester while cts_k=1.
REQ-019 Each accepted edge SHALL cause enc_din=din_k and enc_den=1 on the next clock for exactly one cycle, and nbytes to increment on the same clock.
REQ-020 Edges from the ungranted requester, or while cts_k=0, SHALL be dropped and not counted.
REQ-021 GRANT->FLUSH when the granted rts_k is low; an edge in the same cycle SHALL still be forwarded before enc_rts falls.
REQ-022 FLUSH: enc_rts=0, grant held; SHALL stay until enc_cts=0, then go to GAP.
REQ-023 GAP: grant=2'b00; SHALL count GAP_CYCLES cycles, then go to IDLE and clear nbytes.
REQ-024 rts_k rising during FLUSH/GAP SHALL be held pending and arbitrated in IDLE; no request is lost.
REQ-025 The last-served pointer SHALL update on entry to GRANT.

Reset
REQ-026 On rst=1 at a clock edge: state=IDLE, grant=0, enc_rts=0, enc_den=0, enc_din=0, nbytes=0, den edge registers=0, last-served=1 so requester 0 wins the first tie.
REQ-027 rst during GRANT or FLUSH SHALL abort immediately with no further enc_den pulse; cts0/cts1 SHALL be 0 on the following cycle.

Configuration
REQ-028 With RLE_ARB_QUANTUM_EN defined, GRANT->FLUSH SHALL also occur on the cycle nbytes reaches QUANTUM; the requester keeps rts high and is re-arbitrated after GAP as a new frame; nbytes never wraps.
REQ-029 Without RLE_ARB_QUANTUM_EN, the grant SHALL last until rts drops; nbytes wraps modulo 256.

Verification
REQ-030 Reset: hold rst 3 cycles -> all outputs 0, state=0.
REQ-031 Single requester: rts0=1; send bytes AD,5E,5E,1B; drop rts0 -> grant=01; four enc_den pulses with AD,5E,5E,1B in order; nbytes=4; FLUSH until enc_cts=0; GAP 2 cycles; then IDLE.
REQ-032 Tie: rts0=rts1=1 from reset -> requester 0 served first, then requester 1; repeated tie -> order alternates 0,1,0,1; cts1=0 throughout requester 0's grant.
REQ-033 Intruder: den1 edges with din1=C6 during requester 0's grant -> no enc_den; nbytes unchanged.
REQ-034 Long run: 258 bytes of 77 from requester 0 -> without macro 258 pulses in one frame, nbytes=2; with RLE_ARB_QUANTUM_EN and QUANTUM=255 -> frame of 255, FLUSH, GAP, second frame of 3.
REQ-035 Abort: rst asserted mid-frame after 10 bytes -> next cycle enc_rts=0, grant=0, nbytes=0, no stray enc_den.
